multi_clock_generator: RTL
==========================

Name: multi_clock_generator

Overview:
- Synthesisable, parametrised successor to the single-channel behavioural clock generator.
- Produces NUM_CH independent clock/pulse waveforms, each with programmable phase offset, high time and low time, counted in cycles of the reference clock.
- Adds an optional finite pulse count, start/stop control and per-channel status.
- Sits beside the reference clock as a test-stimulus and timing-pattern source for the sequential-logic blocks.

Parameters:
- NUM_CH, 4, number of independent output channels (1..16)
- CNT_W, 16, width of every phase/ton/toff/pulse-count field and of the internal counters

Ports:
- clk  input  1  reference clock; all logic is on the rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse; latches config and launches all enabled channels
- stop  input  1  single-cycle pulse; aborts all channels
- ch_en  input  NUM_CH  per-channel enable, sampled only on start
- cfg_phase  input  NUM_CH*CNT_W  per-channel delay before first high, in cycles; channel i at [i*CNT_W +: CNT_W] (same packing for all cfg_* buses)
- cfg_ton  input  NUM_CH*CNT_W  per-channel high time, in cycles
- cfg_toff  input  NUM_CH*CNT_W  per-channel low time, in cycles
- cfg_pulses  input  NUM_CH*CNT_W  number of high pulses; 0 = free-running
- clk_out  output  NUM_CH  generated waveforms, registered
- busy  output  NUM_CH  channel is in PHASE/HIGH/LOW
- done  output  NUM_CH  one-cycle pulse when a finite pulse train completes
- cfg_err  output  NUM_CH  sticky; set when a channel is started with ton=0 and toff=0

Behaviour:
- Reset (async assert, sync deassert by the user): clk_out=0, busy=0, done=0, cfg_err=0, all channels IDLE, counters 0.
- Per-channel FSM: IDLE -> PHASE -> HIGH <-> LOW -> IDLE. All outputs are registered.
- Config latch:
  - On the edge E0 where start=1 and stop=0, each channel with ch_en=1 copies phase/ton/toff/pulses into shadow registers.
  - Cfg inputs are ignored at all other times.
- Timing from E0, with P=phase, H=ton, L=toff:
  - clk_out rises at edge E(P+1).
  - Stays high for H cycles.
  - Stays low for L cycles.
  - Repeats with period H+L.
  - Example: P=8, H=3, L=10 -> rises E9, falls E12, rises E22.
- PHASE with P=0 is skipped; HIGH starts immediately (rise at E1).
- ton=0, toff>0: HIGH is skipped; clk_out stays 0; pulses are still counted per period.
- toff=0, ton>0: LOW is skipped; clk_out stays 1 for the whole train.
- ton=0 and toff=0: channel is not launched, busy stays 0, cfg_err is set (cleared only by reset or a later valid start on that channel).
- Finite train (pulses=N>0):
  - After the LOW phase of the N-th period, the channel returns to IDLE.
  - clk_out=0, busy falls, and done=1 for exactly one cycle on that same edge.
  - With toff=0, "after LOW" means after the N-th HIGH.
- Free-running (pulses=0): runs until stop, reset or restart; done never asserts.
- Channels with ch_en=0 at start: if idle, stay idle; if running, keep running unaffected.
- stop: on the sampling edge, all channels go to IDLE, clk_out=0 and busy=0 from the next cycle, no done.
- start and stop in the same cycle: stop wins; no config is latched.
- start while a channel is busy: that channel is restarted with the new config, timing is re-referenced to the new E0, and no done is emitted for the aborted train.
- Counters are CNT_W bits unsigned; the maximum value 2^CNT_W-1 is legal for every field; no wrap occurs within one phase.
- Reset asserted mid-operation: immediate return to reset values regardless of state.

Test Plan:
- Single channel P=8, H=3, L=10, pulses=0, start at E0 -> clk_out rises E9, falls E12, rises E22; period 13 held for at least 10 periods.
- All 4 channels, P={0,1,2,3}, H=2, L=2, pulses=3 -> rises at E1/E2/E3/E4; each channel gives exactly 3 pulses; done pulses once per channel at E13/E14/E15/E16; busy drops on those same edges.
- Edge configs:
  - H=0/L=5 -> clk_out constant 0; done after pulses*5 cycles.
  - H=4/L=0, pulses=2 -> high for 8 cycles, then done.
  - H=0/L=0 -> cfg_err=1, busy=0.
- Free-running channel, stop at cycle 37 -> clk_out=0 and busy=0 from E38; no done; start and stop in the same cycle -> nothing launches.
- Restart: channel running H=5/L=5; start again at cycle 23 with P=2, H=1, L=1 -> new rise at E(23+3); no done from the first train.
- Async reset pulsed low mid-HIGH -> clk_out, busy and cfg_err go to 0 without waiting for a clock edge; the next start behaves as from cold.

Source files
------------

// File: rtl/multi_clock_generator.sv
// Purpose : NUM_CH independent programmable clock/pulse generators (phase, high time, low time, pulse count).
// Latency : clk_out first rises P+1 edges after the start edge; every output is driven from a flop.
// Backpressure: none; start/stop are single-cycle commands that are always accepted, and stop wins over start.
//
// Ports:
//   clk, rst_n                 reference clock and asynchronous active-low reset
//   start, stop                launch (latches cfg for ch_en channels) / abort all channels
//   ch_en                      per-channel enable, sampled only when start is taken
//   cfg_phase/ton/toff/pulses  per-channel config, channel i at [i*CNT_W +: CNT_W]
//   clk_out, busy, done        generated waveform, running flag, end-of-train pulse
//   cfg_err                    sticky flag for a start with ton=0 and toff=0
module multi_clock_generator #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*CNT_W-1:0] cfg_phase,
  input  logic [NUM_CH*CNT_W-1:0] cfg_ton,
  input  logic [NUM_CH*CNT_W-1:0] cfg_toff,
  input  logic [NUM_CH*CNT_W-1:0] cfg_pulses,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH-1:0]       cfg_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PHASE = 2'd1;
  localparam logic [1:0] ST_HIGH  = 2'd2;
  localparam logic [1:0] ST_LOW   = 2'd3;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;       // cycles left in the current phase, minus one
    logic [CNT_W-1:0] pcnt_q, pcnt_d;     // periods left in a finite train
    logic [CNT_W-1:0] ton_q, ton_d;
    logic [CNT_W-1:0] toff_q, toff_d;
    logic [CNT_W-1:0] pulses_q, pulses_d;
    logic             clk_out_q, clk_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             end_period;
    logic             next_period;
    logic [CNT_W-1:0] ph_in, ton_in, toff_in, pulses_in;

    assign ph_in     = cfg_phase[i*CNT_W +: CNT_W];
    assign ton_in    = cfg_ton[i*CNT_W +: CNT_W];
    assign toff_in   = cfg_toff[i*CNT_W +: CNT_W];
    assign pulses_in = cfg_pulses[i*CNT_W +: CNT_W];

    always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pcnt_d      = pcnt_q;
      ton_d       = ton_q;
      toff_d      = toff_q;
      pulses_d    = pulses_q;
      clk_out_d   = clk_out_q;
      done_d      = 1'b0;
      err_d       = err_q;
      end_period  = 1'b0;
      next_period = 1'b0;

      // PHASE is loaded with P and left when it reaches zero, so a zero
      // phase still costs exactly the one cycle that puts the rise at E1.
      case (state_q)
        ST_PHASE: begin
          if (cnt_q == '0) next_period = 1'b1;
          else             cnt_d = cnt_q - ONE;
        end
        ST_HIGH: begin
          if (cnt_q == '0) begin
            if (toff_q != '0) begin
              state_d   = ST_LOW;
              clk_out_d = 1'b0;
              cnt_d     = toff_q - ONE;
            end else begin
              end_period = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        ST_LOW: begin
          if (cnt_q == '0) end_period = 1'b1;
          else             cnt_d = cnt_q - ONE;
        end
        default: ;
      endcase

      // A period ends after its LOW part (or after HIGH when toff is zero).
      if (end_period) begin
        if (pulses_q != '0 && pcnt_q == ONE) begin
          state_d   = ST_IDLE;
          clk_out_d = 1'b0;
          cnt_d     = '0;
          done_d    = 1'b1;
        end else begin
          next_period = 1'b1;
          if (pulses_q != '0) pcnt_d = pcnt_q - ONE;
        end
      end

      // Begin a period; a zero ton goes straight to LOW (toff is then nonzero).
      if (next_period) begin
        if (ton_q != '0) begin
          state_d   = ST_HIGH;
          clk_out_d = 1'b1;
          cnt_d     = ton_q - ONE;
        end else begin
          state_d   = ST_LOW;
          clk_out_d = 1'b0;
          cnt_d     = toff_q - ONE;
        end
      end

      // Commands override the running sequence; an aborted train never signals done.
      if (stop) begin
        state_d   = ST_IDLE;
        clk_out_d = 1'b0;
        cnt_d     = '0;
        done_d    = 1'b0;
      end else if (start && ch_en[i]) begin
        ton_d     = ton_in;
        toff_d    = toff_in;
        pulses_d  = pulses_in;
        pcnt_d    = pulses_in;
        clk_out_d = 1'b0;
        done_d    = 1'b0;
        if (ton_in == '0 && toff_in == '0) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          state_d = ST_PHASE;
          cnt_d   = ph_in;
          err_d   = 1'b0;
        end
      end

      busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= ST_IDLE;
        cnt_q     <= '0;
        pcnt_q    <= '0;
        ton_q     <= '0;
        toff_q    <= '0;
        pulses_q  <= '0;
        clk_out_q <= 1'b0;
        busy_q    <= 1'b0;
        done_q    <= 1'b0;
        err_q     <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        pcnt_q    <= pcnt_d;
        ton_q     <= ton_d;
        toff_q    <= toff_d;
        pulses_q  <= pulses_d;
        clk_out_q <= clk_out_d;
        busy_q    <= busy_d;
        done_q    <= done_d;
        err_q     <= err_d;
      end
    end

    assign clk_out[i] = clk_out_q;
    assign busy[i]    = busy_q;
    assign done[i]    = done_q;
    assign cfg_err[i] = err_q;
  end

endmodule
